// File: rtl/arp_cache_rewrite.sv
// arp_cache_rewrite: next-hop ARP cache lookup and Ethernet header rewrite
// between the LPM stage and the output queues.
module arp_cache_rewrite #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24,
  parameter int ARP_DEPTH            = 32,
  parameter int ARP_ADDR_BITS        = 5,
  parameter int NUM_PORTS            = 4
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  input  logic                              lkp_valid,
  output logic                              lkp_ready,
  input  logic [31:0]                       lkp_nh_ip,
  input  logic [7:0]                        lkp_oq,
  input  logic [48*NUM_PORTS-1:0]           port_mac,
  input  logic                              tbl_wr_en,
  input  logic [ARP_ADDR_BITS-1:0]          tbl_wr_addr,
  input  logic [31:0]                       tbl_wr_ip,
  input  logic [47:0]                       tbl_wr_mac,
  input  logic                              tbl_wr_valid,
  input  logic                              tbl_clear,
  input  logic                              cnt_clear,
  output logic [31:0]                       hit_count,
  output logic [31:0]                       miss_count
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  localparam int SW = DW / 8;
  localparam int FW = 1 + UW + SW + DW;
  localparam int KW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, SEARCH, HEAD, BODY} state_t;

  state_t state, state_nxt;

  logic [FW-1:0] fifo [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    count;
  logic          empty, push, pop;
  logic          head_last;
  logic [UW-1:0] head_user;
  logic [SW-1:0] head_strb;
  logic [DW-1:0] head_data;

  logic [31:0]   tip  [ARP_DEPTH];
  logic [47:0]   tmac [ARP_DEPTH];
  logic [ARP_DEPTH-1:0] tvalid;

  logic [47:0]   pmac [NUM_PORTS];
  logic [31:0]   nh_ip_q;
  logic [7:0]    oq_q;
  logic          hit_q;
  logic [47:0]   mac_q;
  logic [KW-1:0] k_q;
  logic          srch_hit;
  logic [47:0]   srch_mac;
  logic [KW-1:0] srch_k;
  logic          bypass;
  logic [7:0]    miss_dst;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_pmac
    assign pmac[p] = port_mac[48*p +: 48];
  end

  // Fall-through FIFO; ready drops one slot early.
  assign empty         = (count == 3'd0);
  assign S_AXIS_TREADY = (count < 3'd3);
  assign push          = S_AXIS_TVALID && S_AXIS_TREADY;
  assign pop           = M_AXIS_TVALID && M_AXIS_TREADY;
  assign {head_last, head_user, head_strb, head_data} = fifo[rd_ptr];

  always_ff @(posedge AXI_ACLK) begin
    if (push)
      fifo[wr_ptr] <= {S_AXIS_TLAST, S_AXIS_TUSER,
                       S_AXIS_TSTRB, S_AXIS_TDATA};
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b0, push} - {2'b0, pop};
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) begin
      tvalid <= '0;
    end else if (tbl_clear) begin
      tvalid <= '0;
    end else if (tbl_wr_en) begin
      tvalid[tbl_wr_addr] <= tbl_wr_valid;
      tip[tbl_wr_addr]    <= tbl_wr_ip;
      tmac[tbl_wr_addr]   <= tbl_wr_mac;
    end
  end

  // Descending scan so the lowest matching index wins.
  always_comb begin
    srch_hit = 1'b0;
    srch_mac = '0;
    for (int i = ARP_DEPTH - 1; i >= 0; i--) begin
      if (tvalid[i] && tip[i] == nh_ip_q) begin
        srch_hit = 1'b1;
        srch_mac = tmac[i];
      end
    end
  end

  always_comb begin
    srch_k = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (oq_q[2*p]) srch_k = KW'(p);
    end
  end

  assign bypass = (oq_q == 8'd0);

  always_comb begin
    state_nxt = state;
    lkp_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && lkp_valid) begin
          lkp_ready = 1'b1;
          state_nxt = SEARCH;
        end
      end
      SEARCH: state_nxt = HEAD;
      HEAD: begin
        if (pop) state_nxt = head_last ? IDLE : BODY;
      end
      BODY: begin
        if (pop && head_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) begin
      state   <= IDLE;
      nh_ip_q <= '0;
      oq_q    <= '0;
      hit_q   <= 1'b0;
      mac_q   <= '0;
      k_q     <= '0;
    end else begin
      state <= state_nxt;
      if (lkp_ready) begin
        nh_ip_q <= lkp_nh_ip;
        oq_q    <= lkp_oq;
      end
      if (state == SEARCH) begin
        hit_q <= srch_hit;
        mac_q <= srch_mac;
        k_q   <= srch_k;
      end
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN || cnt_clear) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == SEARCH && !bypass) begin
      if (srch_hit) hit_count  <= hit_count + 32'd1;
      else          miss_count <= miss_count + 32'd1;
    end
  end

  // Miss steers to the CPU port paired with the source MAC port.
  assign miss_dst = (head_user[SRC_PORT_POS +: 8] & 8'h55) << 1;

  assign M_AXIS_TVALID = (state == HEAD || state == BODY) && !empty;

  always_comb begin
    M_AXIS_TDATA = head_data;
    M_AXIS_TSTRB = head_strb;
    M_AXIS_TUSER = head_user;
    M_AXIS_TLAST = head_last;
    if (state == HEAD && !bypass) begin
      if (hit_q) begin
        M_AXIS_TDATA[255:208]          = mac_q;
        M_AXIS_TDATA[207:160]          = pmac[k_q];
        M_AXIS_TUSER[DST_PORT_POS +: 8] = oq_q;
      end else begin
        M_AXIS_TUSER[DST_PORT_POS +: 8] = miss_dst;
      end
    end
  end

endmodule
